// File: rtl/sobel_kernel_seq.sv
// Custom-instruction Sobel engine: holds a 3x3 pixel window and walks 12 kernel taps
// through one shared shift/negate coefficient unit, returning |Gx|+|Gy| plus an edge flag.
module sobel_kernel_seq #(
  parameter logic [7:0]  customId       = 8'h19,
  parameter logic [10:0] THRESH_DEFAULT = 11'd256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned PIX_W = 8;
  localparam int unsigned ROW_W = 3 * PIX_W;
  localparam int unsigned ACC_W = 12;
  localparam int unsigned MAG_W = 11;
  localparam int unsigned TAP_W = 4;

  localparam logic [1:0] OP_LOAD    = 2'd0;
  localparam logic [1:0] OP_COMPUTE = 2'd1;
  localparam logic [1:0] OP_SETTH   = 2'd2;
  localparam logic [1:0] OP_CLEAR   = 2'd3;

  typedef enum logic [1:0] {IDLE, ACC, ABS, DONE} state_t;

  state_t                    state_q, state_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic signed [ACC_W-1:0]   gx_q, gx_d, gy_q, gy_d;
  logic [MAG_W-1:0]          thresh_q, thresh_d;
  logic [2:0][ROW_W-1:0]     row_q, row_d;
  logic                      done_q, done_d;
  logic [31:0]               result_q, result_d;

  logic [1:0]                tap_row_c, tap_col_c;
  logic                      tap_neg_c, tap_dbl_c;
  logic [ROW_W-1:0]          sel_row_c;
  logic [PIX_W-1:0]          pix_c;
  logic [ACC_W-1:0]          scaled_c;
  logic signed [ACC_W-1:0]   term_c;
  logic [ACC_W-1:0]          abs_gx_c, abs_gy_c;
  logic [MAG_W-1:0]          mag_c;
  logic                      accept_c;
  logic                      unused_c;

  assign unused_c = ^{valueA[31:24], valueB[31:4]};
  assign accept_c = start && (ciN == customId);

  // Kernel tap table: taps 0-5 build Gx, taps 6-11 build Gy.
  always_comb begin
    tap_row_c = 2'd0;
    tap_col_c = 2'd0;
    tap_neg_c = 1'b0;
    tap_dbl_c = 1'b0;
    case (tap_q)
      4'd0:  begin tap_row_c = 2'd0; tap_col_c = 2'd0; tap_neg_c = 1'b1; end
      4'd1:  begin tap_row_c = 2'd0; tap_col_c = 2'd2; end
      4'd2:  begin tap_row_c = 2'd1; tap_col_c = 2'd0; tap_neg_c = 1'b1; tap_dbl_c = 1'b1; end
      4'd3:  begin tap_row_c = 2'd1; tap_col_c = 2'd2; tap_dbl_c = 1'b1; end
      4'd4:  begin tap_row_c = 2'd2; tap_col_c = 2'd0; tap_neg_c = 1'b1; end
      4'd5:  begin tap_row_c = 2'd2; tap_col_c = 2'd2; end
      4'd6:  begin tap_row_c = 2'd0; tap_col_c = 2'd0; tap_neg_c = 1'b1; end
      4'd7:  begin tap_row_c = 2'd0; tap_col_c = 2'd1; tap_neg_c = 1'b1; tap_dbl_c = 1'b1; end
      4'd8:  begin tap_row_c = 2'd0; tap_col_c = 2'd2; tap_neg_c = 1'b1; end
      4'd9:  begin tap_row_c = 2'd2; tap_col_c = 2'd0; end
      4'd10: begin tap_row_c = 2'd2; tap_col_c = 2'd1; tap_dbl_c = 1'b1; end
      4'd11: begin tap_row_c = 2'd2; tap_col_c = 2'd2; end
      default: ;
    endcase
  end

  // Shared coefficient unit: x1 or x2 (shift) then optional negate.
  always_comb begin
    sel_row_c = row_q[tap_row_c];
    pix_c     = sel_row_c[{tap_col_c, 3'b000} +: PIX_W];
    scaled_c  = tap_dbl_c ? {3'b000, pix_c, 1'b0} : {4'b0000, pix_c};
    term_c    = tap_neg_c ? -$signed(scaled_c) : $signed(scaled_c);
    abs_gx_c  = gx_q[ACC_W-1] ? ACC_W'(-gx_q) : ACC_W'(gx_q);
    abs_gy_c  = gy_q[ACC_W-1] ? ACC_W'(-gy_q) : ACC_W'(gy_q);
    mag_c     = MAG_W'(abs_gx_c) + MAG_W'(abs_gy_c);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      thresh_q <= THRESH_DEFAULT;
      row_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      thresh_q <= thresh_d;
      row_q    <= row_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    gx_d     = gx_q;
    gy_d     = gy_q;
    thresh_d = thresh_q;
    row_d    = row_q;
    done_d   = 1'b0;
    result_d = '0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          case (valueB[1:0])
            OP_LOAD: begin
              if (valueB[3:2] != 2'd3) row_d[valueB[3:2]] = valueA[ROW_W-1:0];
              state_d = DONE;
              done_d  = 1'b1;
            end
            OP_COMPUTE: begin
              gx_d    = '0;
              gy_d    = '0;
              tap_d   = '0;
              state_d = ACC;
            end
            OP_SETTH: begin
              thresh_d = valueA[MAG_W-1:0];
              state_d  = DONE;
              done_d   = 1'b1;
            end
            OP_CLEAR: begin
              row_d   = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ACC: begin
        if (tap_q < TAP_W'(6)) gx_d = gx_q + term_c;
        else                   gy_d = gy_q + term_c;
        if (tap_q == TAP_W'(11)) begin
          tap_d   = '0;
          state_d = ABS;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      ABS: begin
        state_d  = DONE;
        done_d   = 1'b1;
        result_d = {(mag_c >= thresh_q), 20'b0, mag_c};
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_sobel_kernel_seq.sv
// Directed bench for sobel_kernel_seq: latency, Sobel results, threshold edges,
// ignored starts and mid-operation reset.
module tb_sobel_kernel_seq;

  localparam logic [7:0] CID = 8'h19;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  sobel_kernel_seq dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opb(input logic [1:0] row, input logic [1:0] op);
    opb = {28'b0, row, op};
  endfunction

  // Issue one request, then watch 20 cycles for done (exp_lat 0 means none expected).
  task automatic run_op(input string tag, input logic [7:0] n, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat, pulses;
    logic [31:0] res;
    logic stray;
    @(posedge clock); #1;
    start = 1'b1; ciN = n; valueA = a; valueB = b;
    lat = 0; pulses = 0; res = '0; stray = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (done) begin
        pulses++;
        if (lat == 0) begin lat = i; res = result; end
      end else if (result != 0) stray = 1'b1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_pulses"}, 32'(pulses), (exp_lat != 0) ? 32'd1 : 32'd0);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_idle_zero"}, 32'(stray), 32'd0);
  endtask

  initial begin
    int lat, pulses;
    logic [31:0] res;
    reset = 1'b1; start = 1'b0; ciN = '0; valueA = '0; valueB = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);

    // 1: compute on cleared window
    run_op("t1_compute", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h0);

    // 2: bright right column
    run_op("t2_load0", CID, 32'h00FF0000, opb(2'd0, 2'd0), 1, 32'h0);
    run_op("t2_load1", CID, 32'h00FF0000, opb(2'd1, 2'd0), 1, 32'h0);
    run_op("t2_load2", CID, 32'h00FF0000, opb(2'd2, 2'd0), 1, 32'h0);
    run_op("t2_compute", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h800003FC);

    // threshold boundary: mag 1020 against 1020 and 1021
    run_op("th_set1020", CID, 32'd1020, opb(2'd0, 2'd2), 1, 32'h0);
    run_op("th_eq", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h800003FC);
    run_op("th_set1021", CID, 32'd1021, opb(2'd0, 2'd2), 1, 32'h0);
    run_op("th_above", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h000003FC);

    // 3: bottom row full, gx=gy=765
    run_op("t3_load2", CID, 32'h00FFFFFF, opb(2'd2, 2'd0), 1, 32'h0);
    run_op("t3_setth", CID, 32'd2047, opb(2'd0, 2'd2), 1, 32'h0);
    run_op("t3_compute", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h000005FA);

    // 4: flat window, then row index 3 write must not disturb it
    run_op("t4_load0", CID, 32'h00646464, opb(2'd0, 2'd0), 1, 32'h0);
    run_op("t4_load1", CID, 32'h00646464, opb(2'd1, 2'd0), 1, 32'h0);
    run_op("t4_load2", CID, 32'h00646464, opb(2'd2, 2'd0), 1, 32'h0);
    run_op("t4_compute", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h0);
    run_op("t4_load3", CID, 32'h00FF0000, opb(2'd3, 2'd0), 1, 32'h0);
    run_op("t4_after3", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h0);

    // 5: foreign ciN ignored; start during ACC ignored
    run_op("t5_wrongci", 8'h18, 32'h0, opb(2'd0, 2'd0), 0, 32'h0);
    run_op("t5_check", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h0);
    @(posedge clock); #1;
    start = 1'b1; ciN = CID; valueA = '0; valueB = opb(2'd0, 2'd1);
    lat = 0; pulses = 0; res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (i == 3) begin start = 1'b1; valueB = opb(2'd0, 2'd0); end
      if (done) begin
        pulses++;
        if (lat == 0) begin lat = i; res = result; end
      end
    end
    chk("t5_busy_lat", 32'(lat), 32'd14);
    chk("t5_busy_pulses", 32'(pulses), 32'd1);
    chk("t5_busy_res", res, 32'h0);
    run_op("t5_clear", CID, 32'd0, opb(2'd0, 2'd3), 1, 32'h0);
    run_op("t5_compute", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h0);

    // 6: reset during ACC tap 5 abandons the compute
    run_op("t6_load0", CID, 32'h00FF0000, opb(2'd0, 2'd0), 1, 32'h0);
    run_op("t6_load1", CID, 32'h00FF0000, opb(2'd1, 2'd0), 1, 32'h0);
    run_op("t6_load2", CID, 32'h00FF0000, opb(2'd2, 2'd0), 1, 32'h0);
    @(posedge clock); #1;
    start = 1'b1; ciN = CID; valueA = '0; valueB = opb(2'd0, 2'd1);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      reset = (i == 6);
      if (done) pulses++;
    end
    chk("t6_no_done", 32'(pulses), 32'd0);
    chk("t6_result_zero", result, 32'd0);
    run_op("t6_cleared", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h0);
    run_op("t6_rl0", CID, 32'h00FF0000, opb(2'd0, 2'd0), 1, 32'h0);
    run_op("t6_rl1", CID, 32'h00FF0000, opb(2'd1, 2'd0), 1, 32'h0);
    run_op("t6_rl2", CID, 32'h00FF0000, opb(2'd2, 2'd0), 1, 32'h0);
    run_op("t6_thresh256", CID, 32'd0, opb(2'd0, 2'd1), 14, 32'h800003FC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
